// File: rtl/ex_mem_stage_if.sv
// EX/MEM boundary bus: EX-side capture signals, MEM-side head-entry signals,
// branch redirect and overflow-exception signals.
// Optional macro EX_MEM_PERF_CNT_EN adds the performance counter outputs.
interface ex_mem_stage_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
);
   // EX side
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] alu_result;
   logic              alu_zero;
   logic              alu_overflow;
   logic [DATA_W-1:0] pc_in;
   logic [DATA_W-1:0] br_target_in;
   logic [DATA_W-1:0] store_data_in;
   logic [REG_AW-1:0] wreg_in;
   logic              reg_write_in;
   logic              mem_read_in;
   logic              mem_write_in;
   logic              mem_to_reg_in;
   logic              br_eq_in;
   logic              br_ne_in;
   logic              ovf_trap_in;
   // MEM side
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_result;
   logic [DATA_W-1:0] out_store_data;
   logic [REG_AW-1:0] out_wreg;
   logic              out_reg_write;
   logic              out_mem_read;
   logic              out_mem_write;
   logic              out_mem_to_reg;
   // Redirect and exception
   logic              br_taken;
   logic [DATA_W-1:0] br_target;
   logic              exc_ovf;
   logic [DATA_W-1:0] epc;
   logic              exc_ack;
`ifdef EX_MEM_PERF_CNT_EN
   logic [15:0]       ovf_count;
   logic [15:0]       br_taken_count;
`endif

   // Environment view: drives EX inputs, MEM ready and exception acknowledge.
   modport master (
      output in_valid, alu_result, alu_zero, alu_overflow, pc_in, br_target_in,
             store_data_in, wreg_in, reg_write_in, mem_read_in, mem_write_in,
             mem_to_reg_in, br_eq_in, br_ne_in, ovf_trap_in, out_ready, exc_ack,
      input  in_ready, out_valid, out_result, out_store_data, out_wreg,
             out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg,
             br_taken, br_target, exc_ovf, epc
`ifdef EX_MEM_PERF_CNT_EN
      , input ovf_count, br_taken_count
`endif
   );

   // Stage view.
   modport slave (
      input  in_valid, alu_result, alu_zero, alu_overflow, pc_in, br_target_in,
             store_data_in, wreg_in, reg_write_in, mem_read_in, mem_write_in,
             mem_to_reg_in, br_eq_in, br_ne_in, ovf_trap_in, out_ready, exc_ack,
      output in_ready, out_valid, out_result, out_store_data, out_wreg,
             out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg,
             br_taken, br_target, exc_ovf, epc
`ifdef EX_MEM_PERF_CNT_EN
      , output ovf_count, br_taken_count
`endif
   );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline boundary: 2-entry elastic buffer toward MEM, beq/bne
// resolution from ALU Zero, and precise overflow trap with EPC capture.
// Optional macro EX_MEM_PERF_CNT_EN adds saturating ovf/branch counters.
module ex_mem_stage #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input logic               clk,
   input logic               reset,
   ex_mem_stage_if.slave     bus
);

   typedef struct packed {
      logic [DATA_W-1:0] result;
      logic [DATA_W-1:0] store_data;
      logic [REG_AW-1:0] wreg;
      logic              reg_write;
      logic              mem_read;
      logic              mem_write;
      logic              mem_to_reg;
   } entry_t;

   typedef enum logic {RUN, TRAP} state_t;

   state_t            state;
   entry_t            fifo_mem [2];
   logic              rd_ptr;
   logic              wr_ptr;
   logic [1:0]        count;
   entry_t            head;
   entry_t            new_entry;
   logic              accept;
   logic              trap_ev;
   logic              enq;
   logic              deq;
   logic              taken;
   logic              br_fire;
   logic              br_taken;
   logic [DATA_W-1:0] br_target;
   logic              exc_ovf;
   logic [DATA_W-1:0] epc;

   // Handshake decode and head-entry presentation.
   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      bus.in_ready  = 1'b0;
      accept        = 1'b0;
      trap_ev       = 1'b0;
      enq           = 1'b0;
      deq           = 1'b0;
      taken         = 1'b0;
      br_fire       = 1'b0;
      head          = '0;
      new_entry     = '0;

      bus.in_ready  = (state == RUN) && (count != 2'd2);
      accept        = bus.in_valid && bus.in_ready;
      trap_ev       = accept && bus.ovf_trap_in && bus.alu_overflow;
      enq           = accept && !trap_ev;
      deq           = (count != 2'd0) && bus.out_ready;
      taken         = (bus.br_eq_in && bus.alu_zero) || (bus.br_ne_in && !bus.alu_zero);
      br_fire       = enq && taken;

      new_entry.result     = bus.alu_result;
      new_entry.store_data = bus.store_data_in;
      new_entry.wreg       = bus.wreg_in;
      new_entry.reg_write  = bus.reg_write_in;
      new_entry.mem_read   = bus.mem_read_in;
      new_entry.mem_write  = bus.mem_write_in;
      new_entry.mem_to_reg = bus.mem_to_reg_in;

      // An empty buffer presents all-zero fields.
      if (count != 2'd0) head = fifo_mem[rd_ptr];
   end

   assign bus.out_valid      = (count != 2'd0);
   assign bus.out_result     = head.result;
   assign bus.out_store_data = head.store_data;
   assign bus.out_wreg       = head.wreg;
   assign bus.out_reg_write  = head.reg_write;
   assign bus.out_mem_read   = head.mem_read;
   assign bus.out_mem_write  = head.mem_write;
   assign bus.out_mem_to_reg = head.mem_to_reg;
   assign bus.br_taken       = br_taken;
   assign bus.br_target      = br_target;
   assign bus.exc_ovf        = exc_ovf;
   assign bus.epc            = epc;

   // Buffer pointers and occupancy; reset discards any buffered entries.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (enq) wr_ptr <= ~wr_ptr;
         if (deq) rd_ptr <= ~rd_ptr;
         case ({enq, deq})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // Entry storage written at the tail on enqueue.
   // NOTE: the storage array has no reset; count gates what reaches the ports.
   always_ff @(posedge clk) begin
      if (enq) fifo_mem[wr_ptr] <= new_entry;
   end

   // Exception FSM: RUN accepts instructions, TRAP holds until acknowledged.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= RUN;
         exc_ovf <= 1'b0;
         epc     <= '0;
      end else begin
         case (state)
            RUN: begin
               if (trap_ev) begin
                  state   <= TRAP;
                  exc_ovf <= 1'b1;
                  epc     <= bus.pc_in;
               end
            end
            TRAP: begin
               if (bus.exc_ack) begin
                  state   <= RUN;
                  exc_ovf <= 1'b0;
               end
            end
            default: begin
               state   <= RUN;
               exc_ovf <= 1'b0;
            end
         endcase
      end
   end

   // One-cycle redirect pulse; the target holds between pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         br_taken  <= 1'b0;
         br_target <= '0;
      end else begin
         br_taken <= br_fire;
         if (br_fire) br_target <= bus.br_target_in;
      end
   end

`ifdef EX_MEM_PERF_CNT_EN
   logic [15:0] ovf_cnt;
   logic [15:0] br_cnt;

   // Saturating event counters, updated on the same edge as the event's outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         ovf_cnt <= '0;
         br_cnt  <= '0;
      end else begin
         if (trap_ev && (ovf_cnt != 16'hFFFF)) ovf_cnt <= ovf_cnt + 16'd1;
         if (br_fire && (br_cnt != 16'hFFFF))  br_cnt  <= br_cnt + 16'd1;
      end
   end

   assign bus.ovf_count      = ovf_cnt;
   assign bus.br_taken_count = br_cnt;
`endif

endmodule
